// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// Each bit is held for a latched number of clocks (prescale, 0 treated as 1).
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_PRESCALE = 32,
  parameter int unsigned PRSC_WIDTH   = $clog2(MAX_PRESCALE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRSC_WIDTH-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [PRSC_WIDTH-1:0] cnt;
  logic [PRSC_WIDTH-1:0] presc_q;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  bit_end_c;

  // Last clock of the current bit period.
  assign bit_end_c = (cnt == (presc_q - PRSC_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      presc_q    <= PRSC_WIDTH'(1);
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        tx_out <= 1'b1;
        busy   <= 1'b0;
        if (data_valid) begin
          data_q    <= p_data;
          par_en_q  <= par_en;
          par_bit_q <= (^p_data) ^ par_typ;
          presc_q   <= (prescale == '0) ? PRSC_WIDTH'(1) : prescale;
          cnt       <= '0;
          tx_out    <= 1'b0;
          busy      <= 1'b1;
          state     <= START;
        end
      end else if (!bit_end_c) begin
        cnt <= cnt + PRSC_WIDTH'(1);
      end else begin
        // Bit boundary: select the next state and the level it drives.
        cnt <= '0;
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            tx_out  <= data_q[0];
            data_q  <= data_q >> 1;
          end
          DATA: begin
            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
              if (par_en_q) begin
                state  <= PARITY;
                tx_out <= par_bit_q;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              tx_out  <= data_q[0];
              data_q  <= data_q >> 1;
            end
          end
          PARITY: begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
          STOP: begin
            state      <= IDLE;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
          default: begin
            state  <= IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
